reg_write_arbiter: RTL

- Shares the single write port of the 4-entry register bank among four requesters.
- Arbitration is round-robin, with optional locked bursts.
- Drives the registered write address and data plus the write enable consumed by the bank's 2-to-4 write-address decoder, which gates the per-entry write strobes with `io_WEN`.
- Sits between the requester interfaces and the register-bank write port.

---
 rtl/reg_write_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among four
// requesters, with optional locked bursts of up to MAX_BURST transfers.
module reg_write_arbiter #(
   parameter int unsigned W         = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         io_REQ_0_valid,
   input  logic [1:0]   io_REQ_0_addr,
   input  logic [W-1:0] io_REQ_0_data,
   input  logic         io_REQ_0_lock,
   output logic         io_REQ_0_ready,
   input  logic         io_REQ_1_valid,
   input  logic [1:0]   io_REQ_1_addr,
   input  logic [W-1:0] io_REQ_1_data,
   input  logic         io_REQ_1_lock,
   output logic         io_REQ_1_ready,
   input  logic         io_REQ_2_valid,
   input  logic [1:0]   io_REQ_2_addr,
   input  logic [W-1:0] io_REQ_2_data,
   input  logic         io_REQ_2_lock,
   output logic         io_REQ_2_ready,
   input  logic         io_REQ_3_valid,
   input  logic [1:0]   io_REQ_3_addr,
   input  logic [W-1:0] io_REQ_3_data,
   input  logic         io_REQ_3_lock,
   output logic         io_REQ_3_ready,
   output logic [1:0]   io_WADD,
   output logic [W-1:0] io_WDATA,
   output logic         io_WEN,
   output logic         io_BUSY,
   output logic [1:0]   io_OWNER
);

   localparam int unsigned CW       = $clog2(MAX_BURST + 1);
   localparam bit          BURST_EN = (MAX_BURST > 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          state, state_d;
   logic [1:0]      ptr, ptr_d;
   logic [1:0]      owner, owner_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic [CW-1:0]   cnt_inc;

   logic [3:0]      valid;
   logic [3:0]      lock;
   logic [1:0]      addr [4];
   logic [W-1:0]    data [4];

   logic [3:0]      grant;
   logic            xfer;
   logic [1:0]      sel;
   logic [1:0]      win;
   logic            win_found;

   logic            wen_q;
   logic [1:0]      wadd_q;
   logic [W-1:0]    wdata_q;

   assign valid   = {io_REQ_3_valid, io_REQ_2_valid, io_REQ_1_valid, io_REQ_0_valid};
   assign lock    = {io_REQ_3_lock, io_REQ_2_lock, io_REQ_1_lock, io_REQ_0_lock};
   assign addr[0] = io_REQ_0_addr;
   assign addr[1] = io_REQ_1_addr;
   assign addr[2] = io_REQ_2_addr;
   assign addr[3] = io_REQ_3_addr;
   assign data[0] = io_REQ_0_data;
   assign data[1] = io_REQ_1_data;
   assign data[2] = io_REQ_2_data;
   assign data[3] = io_REQ_3_data;

   assign cnt_inc = cnt + CW'(1);

   // Round-robin search: scan from the farthest slot back so the slot nearest ptr wins.
   always_comb begin
      win       = ptr;
      win_found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (valid[ptr + 2'(i)]) begin
            win       = ptr + 2'(i);
            win_found = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= 2'd0;
         owner <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= state_d;
         ptr   <= ptr_d;
         owner <= owner_d;
         cnt   <= cnt_d;
      end
   end

   // Next-state, grant and transfer decode.
   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      owner_d = owner;
      cnt_d   = cnt;
      grant   = 4'b0000;
      xfer    = 1'b0;
      sel     = owner;
      case (state)
         IDLE: begin
            if (win_found) begin
               grant[win] = 1'b1;
               sel        = win;
               xfer       = 1'b1;
               ptr_d      = win + 2'd1;
               owner_d    = win;
               if (BURST_EN && lock[win]) begin
                  state_d = LOCKED;
                  cnt_d   = CW'(1);
               end
            end
         end
         LOCKED: begin
            // Owner keeps the port; a missing valid forfeits the lock.
            grant[owner] = 1'b1;
            if (valid[owner]) begin
               xfer = 1'b1;
               if (!lock[owner]) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CW'(MAX_BURST)) begin
                     state_d = IDLE;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // Write-port register; address/data hold when no transfer occurs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wen_q   <= 1'b0;
         wadd_q  <= 2'd0;
         wdata_q <= '0;
      end else begin
         wen_q <= xfer;
         if (xfer) begin
            wadd_q  <= addr[sel];
            wdata_q <= data[sel];
         end
      end
   end

   // Grants are suppressed while reset is held.
   assign io_REQ_0_ready = grant[0] & reset;
   assign io_REQ_1_ready = grant[1] & reset;
   assign io_REQ_2_ready = grant[2] & reset;
   assign io_REQ_3_ready = grant[3] & reset;

   assign io_WADD  = wadd_q;
   assign io_WDATA = wdata_q;
   assign io_WEN   = wen_q;
   assign io_BUSY  = (state == LOCKED);
   assign io_OWNER = owner;

endmodule
